// File: rtl/radar_frame_tx.sv
// radar_frame_tx: buffers 16-bit radar samples and streams them as A5 5A-framed bytes to a UART.
// Define RADAR_FRAME_CHECKSUM_EN to append a modulo-256 payload checksum byte to each frame.
module radar_frame_tx #(
  parameter int SAMPLES_PER_FRAME = 8,
  parameter int FIFO_DEPTH        = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sample_valid,
  input  logic [15:0] sample_data,
  output logic        sample_ready,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        overflow,
  output logic [15:0] frame_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] SPF_C    = CW'(SAMPLES_PER_FRAME);
  localparam logic [AW-1:0] LAST_PTR = AW'(FIFO_DEPTH - 1);
  localparam logic [7:0]    SPF_8    = 8'(SAMPLES_PER_FRAME);

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    DATA_HI,
    DATA_LO
`ifdef RADAR_FRAME_CHECKSUM_EN
    , CKSUM
`endif
  } state_t;

  typedef enum logic [1:0] {
    ISSUE,
    WAIT_HI,
    WAIT_LO
  } phase_t;

  state_t state;
  phase_t phase;

  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic [15:0]   head;
  logic [7:0]    latched_lo;
  logic [7:0]    sample_cnt;
`ifdef RADAR_FRAME_CHECKSUM_EN
  logic [7:0]    checksum;
`endif

  // Ready comes from the occupancy register, so a pop in a full cycle cannot admit a push.
  assign sample_ready = (count != DEPTH_C);
  assign push         = sample_valid && sample_ready;
  assign pop          = (state == DATA_HI) && (phase == ISSUE);
  assign head         = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sample_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + AW'(1);
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (sample_valid && !sample_ready) overflow <= 1'b1;
    end
  end

  // Every byte goes through ISSUE -> WAIT_HI (busy seen) -> WAIT_LO (busy released).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      phase       <= ISSUE;
      tx_start    <= 1'b0;
      tx_data     <= 8'h00;
      frame_count <= 16'h0000;
      sample_cnt  <= 8'h00;
      latched_lo  <= 8'h00;
`ifdef RADAR_FRAME_CHECKSUM_EN
      checksum    <= 8'h00;
`endif
    end else begin
      tx_start <= 1'b0;
      if (state == IDLE) begin
        phase <= ISSUE;
        if (count >= SPF_C) begin
          state      <= HDR0;
          sample_cnt <= 8'h00;
`ifdef RADAR_FRAME_CHECKSUM_EN
          checksum   <= 8'h00;
`endif
        end
      end else begin
        case (phase)
          ISSUE: begin
            tx_start <= 1'b1;
            phase    <= WAIT_HI;
            case (state)
              HDR0:    tx_data <= 8'hA5;
              HDR1:    tx_data <= 8'h5A;
              DATA_HI: begin
                tx_data    <= head[15:8];
                latched_lo <= head[7:0];
                sample_cnt <= sample_cnt + 8'd1;
`ifdef RADAR_FRAME_CHECKSUM_EN
                checksum   <= checksum + head[15:8];
`endif
              end
              DATA_LO: begin
                tx_data  <= latched_lo;
`ifdef RADAR_FRAME_CHECKSUM_EN
                checksum <= checksum + latched_lo;
`endif
              end
`ifdef RADAR_FRAME_CHECKSUM_EN
              CKSUM:   tx_data <= checksum;
`endif
              default: tx_data <= 8'h00;
            endcase
          end
          WAIT_HI: begin
            if (tx_busy) phase <= WAIT_LO;
          end
          WAIT_LO: begin
            if (!tx_busy) begin
              phase <= ISSUE;
              case (state)
                HDR0:    state <= HDR1;
                HDR1:    state <= DATA_HI;
                DATA_HI: state <= DATA_LO;
                DATA_LO: begin
                  if (sample_cnt == SPF_8) begin
`ifdef RADAR_FRAME_CHECKSUM_EN
                    state       <= CKSUM;
`else
                    state       <= IDLE;
                    frame_count <= frame_count + 16'd1;
`endif
                  end else begin
                    state <= DATA_HI;
                  end
                end
`ifdef RADAR_FRAME_CHECKSUM_EN
                CKSUM: begin
                  state       <= IDLE;
                  frame_count <= frame_count + 16'd1;
                end
`endif
                default: state <= IDLE;
              endcase
            end
          end
          default: phase <= ISSUE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_radar_frame_tx.sv
// Self-checking bench for radar_frame_tx: randomized samples and UART busy timing against a frame-level model.
`timescale 1ns/1ps
module tb_radar_frame_tx;
  localparam int SPF   = 2;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_data = 16'h0000;
  logic        sample_ready;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        overflow;
  logic [15:0] frame_count;

  logic uart_busy = 1'b0;
  logic hold_busy = 1'b0;
  int   busy_delay = 0;
  int   busy_len = 2;
  int   delay_cnt = 0;
  int   hold_cnt = 0;
  bit   pending = 1'b0;

  int errors = 0;
  int checks = 0;
  int exp_frames = 0;
  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];
  logic [15:0] model_q[$];

  assign tx_busy = uart_busy | hold_busy;

  always #5 clk = ~clk;

  radar_frame_tx #(
    .SAMPLES_PER_FRAME(SPF),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .sample_valid(sample_valid),
    .sample_data(sample_data),
    .sample_ready(sample_ready),
    .tx_data(tx_data),
    .tx_start(tx_start),
    .tx_busy(tx_busy),
    .overflow(overflow),
    .frame_count(frame_count)
  );

  // UART model: records each tx_start byte, raises busy after busy_delay cycles for busy_len cycles.
  always @(negedge clk) begin
    if (!reset_n) begin
      pending   = 1'b0;
      uart_busy = 1'b0;
      delay_cnt = 0;
      hold_cnt  = 0;
    end else begin
      if (tx_start) begin
        got_q.push_back(tx_data);
        pending   = 1'b1;
        delay_cnt = busy_delay;
      end
      if (pending) begin
        if (delay_cnt == 0) begin
          pending   = 1'b0;
          uart_busy = 1'b1;
          hold_cnt  = busy_len;
        end else begin
          delay_cnt--;
        end
      end else if (uart_busy) begin
        if (hold_cnt <= 1) uart_busy = 1'b0;
        else hold_cnt--;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] d);
    @(negedge clk);
    sample_valid = 1'b1;
    sample_data  = d;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic pushSample(input logic [15:0] d);
    applyStimulus(d);
    model_q.push_back(d);
  endtask

  // Builds the expected byte stream of one frame from the oldest buffered samples.
  task automatic expectFrame();
    int sum;
    logic [15:0] s;
    sum = 0;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    for (int i = 0; i < SPF; i++) begin
      s = model_q.pop_front();
      exp_q.push_back(s[15:8]);
      exp_q.push_back(s[7:0]);
      sum = sum + int'(s[15:8]) + int'(s[7:0]);
    end
`ifdef RADAR_FRAME_CHECKSUM_EN
    exp_q.push_back(8'(sum % 256));
`endif
    exp_frames++;
  endtask

  task automatic waitFrames(input int target, input int budget);
    int n;
    n = 0;
    while (frame_count != 16'(target) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("frame_count", 32'(frame_count), 32'(target));
  endtask

  task automatic compareBytes(input string tag);
    checkOutput({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      checkOutput($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("rst_ready", 32'(sample_ready), 32'd1);
    checkOutput("rst_tx_start", 32'(tx_start), 32'd0);
    checkOutput("rst_tx_data", 32'(tx_data), 32'h00);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_frame_count", 32'(frame_count), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Reference frame: 0x1234, 0xABCD.
    busy_delay = 0;
    busy_len   = 2;
    pushSample(16'h1234);
    pushSample(16'hABCD);
    expectFrame();
    waitFrames(exp_frames, 1000);
    checkOutput("ref_hdr0", 32'(got_q[0]), 32'hA5);
    checkOutput("ref_lo_last", 32'(got_q[5]), 32'hCD);
`ifdef RADAR_FRAME_CHECKSUM_EN
    checkOutput("ref_cksum", 32'(got_q[6]), 32'hBE);
    checkOutput("ref_len", 32'(got_q.size()), 32'd7);
`else
    checkOutput("ref_len", 32'(got_q.size()), 32'd6);
`endif
    compareBytes("ref");

    // One sample short of a frame must not start transmission.
    for (int i = 0; i < SPF - 1; i++) pushSample(16'($urandom));
    repeat (60) @(negedge clk);
    checkOutput("partial_no_start", 32'(got_q.size()), 32'd0);
    pushSample(16'($urandom));
    expectFrame();
    waitFrames(exp_frames, 1000);
    compareBytes("partial");

    // Random rounds: two frames' samples pushed with gaps while the first frame is in flight.
    for (int r = 0; r < 5; r++) begin
      busy_delay = (r == 0) ? 3 : int'($urandom_range(0, 3));
      busy_len   = int'($urandom_range(1, 4));
      for (int i = 0; i < 2 * SPF; i++) begin
        pushSample(16'($urandom));
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      expectFrame();
      expectFrame();
      waitFrames(exp_frames, 2000);
      compareBytes($sformatf("rand%0d", r));
    end
    checkOutput("rand_overflow", 32'(overflow), 32'd0);

    // Reset while waiting on the first DATA_LO byte.
    busy_delay = 0;
    busy_len   = 12;
    pushSample(16'h0F0F);
    pushSample(16'h7788);
    begin
      int n;
      n = 0;
      while (got_q.size() < 4 && n < 500) begin
        @(negedge clk);
        n++;
      end
    end
    checkOutput("mid_reached_data_lo", 32'(got_q.size()), 32'd4);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_tx_start", 32'(tx_start), 32'd0);
    checkOutput("mid_rst_tx_data", 32'(tx_data), 32'h00);
    checkOutput("mid_rst_ready", 32'(sample_ready), 32'd1);
    checkOutput("mid_rst_overflow", 32'(overflow), 32'd0);
    checkOutput("mid_rst_frame_count", 32'(frame_count), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    got_q.delete();
    exp_q.delete();
    model_q.delete();
    exp_frames = 0;
    busy_len = 2;
    repeat (20) @(negedge clk);
    checkOutput("mid_no_start_after_reset", 32'(got_q.size()), 32'd0);
    pushSample(16'($urandom));
    pushSample(16'($urandom));
    expectFrame();
    waitFrames(exp_frames, 1000);
    compareBytes("after_reset");

    // Overflow: transmitter held busy, 17 pushes into a 16-deep FIFO.
    hold_busy = 1'b1;
    for (int i = 0; i < DEPTH - 1; i++) applyStimulus(16'(i));
    checkOutput("ovf_ready_at_15", 32'(sample_ready), 32'd1);
    applyStimulus(16'h00FF);
    checkOutput("ovf_ready_at_16", 32'(sample_ready), 32'd0);
    checkOutput("ovf_flag_before", 32'(overflow), 32'd0);
    applyStimulus(16'hDEAD);
    checkOutput("ovf_flag_after", 32'(overflow), 32'd1);
    checkOutput("ovf_ready_after", 32'(sample_ready), 32'd0);
    repeat (5) @(negedge clk);
    checkOutput("ovf_flag_sticky", 32'(overflow), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/radar_frame_tx.md
RADAR_FRAME_TX -- requirements
Module: radar_frame_tx

Interface
REQ-001 Parameter SAMPLES_PER_FRAME, default 8, SHALL set the number of 16-bit samples per frame (legal 1..255).
REQ-002 Parameter FIFO_DEPTH, default 16, SHALL set the sample FIFO depth (power of 2, at least SAMPLES_PER_FRAME).
REQ-003 Ports SHALL be:
- clk  in  1  system clock, all logic on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- sample_valid  in  1  sample_data is offered this cycle.
- sample_data  in  16  radar sample.
- sample_ready  out  1  FIFO not full.
- tx_data  out  8  byte to the UART transmitter.
- tx_start  out  1  one-cycle pulse requesting transmission of tx_data.
- tx_busy  in  1  UART transmitter busy.
- overflow  out  1  sticky flag: a sample was dropped.
- frame_count  out  16  number of completed frames.

Function
REQ-004 A sample SHALL be written to the FIFO when sample_valid=1 and sample_ready=1; sample_ready SHALL equal !full, registered from the state at the start of the cycle.
REQ-005 When sample_valid=1 and full=1, the sample SHALL be dropped and overflow set to 1 until reset.
REQ-006 A same-cycle push and pop SHALL be allowed, with occupancy unchanged; a pop from a full FIFO SHALL NOT admit a push in the same cycle.
REQ-007 Frame byte order SHALL be 0xA5, 0x5A, then for each sample the high byte then the low byte, then the checksum byte when it is enabled (REQ-016).
REQ-008 FSM states SHALL be IDLE, HDR0, HDR1, DATA_HI, DATA_LO, CKSUM; each byte state SHALL have the sub-phases ISSUE, WAIT_HI, WAIT_LO.
REQ-009 IDLE SHALL go to HDR0 only when FIFO occupancy >= SAMPLES_PER_FRAME, so a frame is never started without all its samples buffered.
REQ-010 ISSUE SHALL drive tx_data and pulse tx_start for exactly one cycle, then go to WAIT_HI.
REQ-011 WAIT_HI SHALL advance when tx_busy=1; WAIT_LO SHALL advance to the next byte state's ISSUE when tx_busy=0.
REQ-012 The FIFO SHALL pop and latch one sample in the ISSUE cycle of DATA_HI; DATA_LO SHALL send the low byte of the latched sample.
REQ-013 An 8-bit sample counter SHALL select DATA_HI after DATA_LO until SAMPLES_PER_FRAME samples are sent, then select CKSUM, or IDLE when the checksum is disabled.
REQ-014 The checksum SHALL be the modulo-256 sum of all payload bytes, excluding the header, and SHALL be cleared on entry to HDR0.
REQ-015 On frame completion, frame_count SHALL increment, wrapping from 0xFFFF to 0x0000; IDLE SHALL be able to start the next frame in the following cycle.

Configuration
REQ-016 With macro RADAR_FRAME_CHECKSUM_EN defined, the CKSUM byte SHALL be sent; without it, the CKSUM state and the accumulator SHALL be absent and frames SHALL end after the last DATA_LO byte.

Reset
REQ-017 reset_n=0 SHALL asynchronously set: FSM to IDLE, FIFO empty, sample_ready=1, tx_start=0, tx_data=0x00, overflow=0, frame_count=0, checksum=0, sample counter=0.
REQ-018 Reset during a frame SHALL abandon the frame, with no further tx_start pulses until a new frame qualifies.

Verification
REQ-019 With SAMPLES_PER_FRAME=2, push 0x1234 and 0xABCD -> bytes A5 5A 12 34 AB CD BE, and frame_count=1.
REQ-020 Same setup with the macro undefined -> A5 5A 12 34 AB CD, no seventh tx_start.
REQ-021 Push only SAMPLES_PER_FRAME-1 samples -> tx_start stays 0 indefinitely; after one more push the frame starts.
REQ-022 With FIFO_DEPTH=16, tx_busy held at 1 and 17 pushes -> sample_ready=0 after the 16th push, the 17th sample is dropped, and overflow=1.
REQ-023 Delay tx_busy rising by 3 cycles after each tx_start -> exactly one tx_start per byte, with no duplicates.
REQ-024 Assert reset_n=0 during a DATA_LO wait -> all outputs at reset values, and the next frame after refill starts with 0xA5.
